ahb_bus_matrix_1xn: RTL and testbench
=====================================

# ahb_bus_matrix_1xn

Parametrised single-master AHB-Lite address decoder and response multiplexer for the PVS SoC. It replaces the fixed 8-way decoder/mux pair with one block that has:
- a configurable slave count and address map;
- a registered data-phase select;
- a built-in default slave that returns a two-cycle ERROR for unmapped addresses;
- an optional per-transfer wait-state watchdog.

It sits between the CPU AHB master port and all AHB slaves, including the peripheral sub-decoder.

## Interface
- NSLV, 8: number of slave ports, 1..16.
- ADDR_W, 32: HADDR width.
- SLV_BASE, NSLV*ADDR_W bits: packed base addresses. Slave i uses bits [i*ADDR_W +: ADDR_W].
- SLV_MASK, NSLV*ADDR_W bits: packed match masks, same packing as SLV_BASE.
- TIMEOUT, 255: maximum consecutive wait cycles before forced ERROR. Used only with the macro.
- HCLK  in  1  bus clock, rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HADDR  in  ADDR_W  master address.
- HTRANS  in  2  master transfer type.
- HREADY_M  out  1  ready returned to the master. Also broadcast to slaves as HREADY.
- HRESP_M  out  2  response to the master: 00 = OKAY, 01 = ERROR.
- HRDATA_M  out  32  read data to the master.
- HSEL_S  out  NSLV  one-hot slave select, combinational from HADDR.
- HREADYOUT_S  in  NSLV  per-slave ready.
- HRESP_S  in  NSLV*2  per-slave response.
- HRDATA_S  in  NSLV*32  per-slave read data.
- TOUT_IRQ  out  1  sticky watchdog flag.
- TOUT_SLV  out  4  index of the slave that timed out.
- TOUT_CLR  in  1  clears TOUT_IRQ, synchronous.

## Operation
- Decode
  - Slave i matches when (HADDR & MASK_i) == BASE_i.
  - Overlapping regions resolve to the lowest index.
  - HSEL_S is one-hot or all-zero and is asserted independent of HTRANS.
  - No match selects the default slave.
- Address→data handoff
  - On a rising edge with HREADY_M=1, the block registers:
    - dsel: the matched index, or DEFAULT.
    - dact: 1 when HTRANS[1]=1 (NONSEQ or SEQ).
  - dsel and dact hold while HREADY_M=0.
- Data-phase mux
  - When dsel is a real slave: HRDATA_M, HREADY_M and HRESP_M come from that slave.
  - When dsel = DEFAULT, or dact=0 with a real slave: HRDATA_M=0.
- Default slave
  - dact=0 (IDLE/BUSY): zero-wait OKAY, HREADY_M=1, HRESP_M=00.
  - dact=1 (unmapped NONSEQ/SEQ): two-cycle ERROR.
    - Cycle E1: HREADY_M=0, HRESP_M=01.
    - Cycle E2: HREADY_M=1, HRESP_M=01.
  - States: D_IDLE → D_ERR1 → D_ERR2 → D_IDLE, or → D_ERR1 directly if the next transfer is also unmapped.
- Slave ERROR responses pass through unchanged. The block never shortens them.
- A slave with dact=0 is not consulted for ready: HREADY_M is forced to 1.

## Timing
- HSEL_S: zero-latency combinational.
- Data-phase outputs: combinational from the registered dsel plus slave inputs. There is no added wait state for mapped slaves.
- Unmapped transfer: exactly 2 data-phase cycles.
- Reset values:
  - dsel=DEFAULT, dact=0, default FSM=D_IDLE.
  - HREADY_M=1, HRESP_M=00, HRDATA_M=0.
  - TOUT_IRQ=0, TOUT_SLV=0, wait counter=0.
- Reset asserted mid-transfer:
  - All state returns to the reset values immediately, asynchronously.
  - The pending data phase is abandoned. The master sees HREADY_M=1 with OKAY.
- Back-to-back transfers: the address phase of N+1 overlaps the data phase of N. The new dsel is captured only on the HREADY_M=1 edge.

## Configuration
- AHB_MATRIX_TIMEOUT_EN defined:
  - An 8-bit saturating counter counts consecutive cycles with dact=1, dsel=real slave and HREADYOUT_S[dsel]=0.
  - The counter clears on HREADYOUT_S[dsel]=1 or on a new data phase.
  - On reaching TIMEOUT, the block overrides the slave and drives the E1/E2 ERROR sequence to the master.
  - Also at that point: TOUT_IRQ is set and TOUT_SLV is set to dsel.
  - HREADY_M=1 in E2 ends the transfer for the stalled slave.
  - TOUT_CLR clears TOUT_IRQ. If TOUT_CLR and a new timeout occur in the same cycle, set wins.
- AHB_MATRIX_TIMEOUT_EN undefined:
  - No counter logic is built.
  - TOUT_IRQ=0 and TOUT_SLV=0 permanently.
  - TOUT_CLR is ignored.
  - Waits pass through without limit.

## Test plan
- Mapped read: NSLV=8, slave 3 BASE=0x1000_0000, MASK=0xF000_0000. NONSEQ read at 0x1000_0040, slave returns 0xDEADBEEF with zero waits → next cycle HRDATA_M=0xDEADBEEF, HREADY_M=1, HRESP_M=00.
- Unmapped: NONSEQ at 0xE000_0000 followed by IDLE → E1: HREADY_M=0, HRESP_M=01; E2: HREADY_M=1, HRESP_M=01; then OKAY.
- Wait states and pipelining: slave 1 holds HREADYOUT low 3 cycles while the master holds a NONSEQ to slave 2 in its address phase → dsel stays at 1 for 4 cycles, then switches to 2; slave 2 data is returned on the following cycle.
- Overlap: slaves 0 and 5 both match 0x0000_0100 → HSEL_S=0x01.
- Timeout, macro defined, TIMEOUT=4: slave 6 holds HREADYOUT low indefinitely → after 4 wait cycles, E1 then E2 ERROR; TOUT_IRQ=1, TOUT_SLV=6. Pulse TOUT_CLR → TOUT_IRQ=0. With the macro undefined, the same stimulus leaves HREADY_M=0 indefinitely.
- Async reset: assert HRESET during E1 → HREADY_M=1, HRESP_M=00 within the same cycle; after release, the first mapped transfer completes normally.

Source files
------------

// File: rtl/ahb_bus_matrix_1xn.sv
// AHB-Lite 1xN address decoder and response mux with a built-in default slave.
// Optional wait-state watchdog is built when AHB_MATRIX_TIMEOUT_EN is defined.
module ahb_bus_matrix_1xn #(
  parameter int                     NSLV     = 8,
  parameter int                     ADDR_W   = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '1,
  parameter int                     TIMEOUT  = 255
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [ADDR_W-1:0]  HADDR,
  input  logic [1:0]         HTRANS,
  output logic               HREADY_M,
  output logic [1:0]         HRESP_M,
  output logic [31:0]        HRDATA_M,
  output logic [NSLV-1:0]    HSEL_S,
  input  logic [NSLV-1:0]    HREADYOUT_S,
  input  logic [NSLV*2-1:0]  HRESP_S,
  input  logic [NSLV*32-1:0] HRDATA_S,
  output logic               TOUT_IRQ,
  output logic [3:0]         TOUT_SLV,
  input  logic               TOUT_CLR
);

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_ERR1 = 2'd1;
  localparam logic [1:0] D_ERR2 = 2'd2;

  logic        r_ddef;
  logic [3:0]  r_dsel;
  logic        r_dact;
  logic [1:0]  r_dst;

  logic        w_hit;
  logic [3:0]  w_idx;
  logic        w_srdy;
  logic [1:0]  w_sresp;
  logic [31:0] w_sdata;
  logic        w_tout;
  logic        w_unused;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[i*ADDR_W +: ADDR_W])
          == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        w_hit = 1'b1;
        w_idx = 4'(i);
      end
    end
  end

  always_comb begin
    HSEL_S = '0;
    for (int i = 0; i < NSLV; i++)
      HSEL_S[i] = w_hit && (w_idx == 4'(i));
  end

  always_comb begin
    w_srdy  = 1'b1;
    w_sresp = 2'b00;
    w_sdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_dsel == 4'(i)) begin
        w_srdy  = HREADYOUT_S[i];
        w_sresp = HRESP_S[i*2 +: 2];
        w_sdata = HRDATA_S[i*32 +: 32];
      end
    end
  end

  always_comb begin
    HREADY_M = 1'b1;
    HRESP_M  = 2'b00;
    HRDATA_M = '0;
    unique case (1'b1)
      (r_dst == D_ERR1): begin
        HREADY_M = 1'b0;
        HRESP_M  = 2'b01;
      end
      (r_dst == D_ERR2): begin
        HRESP_M  = 2'b01;
      end
      (r_dst == D_IDLE && !r_ddef && r_dact): begin
        HREADY_M = w_srdy;
        HRESP_M  = w_sresp;
        HRDATA_M = w_sdata;
      end
      default: ;
    endcase
  end

  // Data-phase owner only advances when the master sees ready.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_ddef <= 1'b1;
      r_dsel <= '0;
      r_dact <= 1'b0;
      r_dst  <= D_IDLE;
    end else if (HREADY_M) begin
      r_ddef <= !w_hit;
      r_dsel <= w_idx;
      r_dact <= HTRANS[1];
      r_dst  <= (!w_hit && HTRANS[1]) ? D_ERR1 : D_IDLE;
    end else if (r_dst == D_ERR1) begin
      r_dst  <= D_ERR2;
    end else if (w_tout) begin
      r_dst  <= D_ERR1;
    end
  end

`ifdef AHB_MATRIX_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_irq;
  logic [3:0] r_tslv;
  logic       w_wait;

  assign w_wait = (r_dst == D_IDLE) && r_dact && !r_ddef && !w_srdy;
  assign w_tout = w_wait && (({1'b0, r_cnt} + 9'd1) >= 9'(TIMEOUT));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cnt  <= '0;
      r_irq  <= 1'b0;
      r_tslv <= '0;
    end else begin
      if (HREADY_M || w_srdy)
        r_cnt <= '0;
      else if (w_wait && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
      if (w_tout) begin
        r_irq  <= 1'b1;
        r_tslv <= r_dsel;
      end else if (TOUT_CLR) begin
        r_irq  <= 1'b0;
      end
    end
  end

  assign TOUT_IRQ = r_irq;
  assign TOUT_SLV = r_tslv;
  assign w_unused = HTRANS[0];
`else
  assign w_tout   = 1'b0;
  assign TOUT_IRQ = 1'b0;
  assign TOUT_SLV = 4'd0;
  assign w_unused = ^{HTRANS[0], TOUT_CLR};
`endif

endmodule

// File: tb/tb_ahb_bus_matrix_1xn.sv
// Scoreboard bench for ahb_bus_matrix_1xn: expected master-side responses
// are queued as stimulus is driven and popped at the following negedge.
module tb_ahb_bus_matrix_1xn;

  localparam int NSLV = 8;
  localparam int AW   = 32;
  localparam logic [NSLV*AW-1:0] BASE = {
    32'h7000_0000, 32'h6000_0000, 32'h0000_0000, 32'h4000_0000,
    32'h1000_0000, 32'h3000_0000, 32'h2000_0000, 32'h0000_0000};
  localparam logic [NSLV*AW-1:0] MASK = {
    32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000,
    32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic               HCLK = 1'b0;
  logic               HRESET = 1'b1;
  logic [AW-1:0]      HADDR = '0;
  logic [1:0]         HTRANS = 2'b00;
  logic               HREADY_M;
  logic [1:0]         HRESP_M;
  logic [31:0]        HRDATA_M;
  logic [NSLV-1:0]    HSEL_S;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [NSLV*2-1:0]  HRESP_S;
  logic [NSLV*32-1:0] HRDATA_S;
  logic               TOUT_IRQ;
  logic [3:0]         TOUT_SLV;
  logic               TOUT_CLR = 1'b0;

  exp_t q[$];
  exp_t e;
  int   n_tot = 0;
  int   n_bad = 0;

  ahb_bus_matrix_1xn #(
    .NSLV(NSLV), .ADDR_W(AW), .SLV_BASE(BASE),
    .SLV_MASK(MASK), .TIMEOUT(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY_M(HREADY_M), .HRESP_M(HRESP_M), .HRDATA_M(HRDATA_M),
    .HSEL_S(HSEL_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
    .HRDATA_S(HRDATA_S), .TOUT_IRQ(TOUT_IRQ), .TOUT_SLV(TOUT_SLV),
    .TOUT_CLR(TOUT_CLR)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] dflt(int i);
    return 32'hA5A5_0000 + 32'(i);
  endfunction

  function automatic exp_t obs();
    return exp_t'({HREADY_M, HRESP_M, HRDATA_M});
  endfunction

  task automatic set_slv(int i, logic rdy, logic [1:0] rsp, logic [31:0] d);
    HREADYOUT_S[i]     = rdy;
    HRESP_S[i*2 +: 2]  = rsp;
    HRDATA_S[i*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NSLV; i++) set_slv(i, 1'b1, 2'b00, dflt(i));
    q.push_back(exp_t'{1'b1, 2'b00, 32'h0});
    @(negedge HCLK);
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL reset_bus got=%h want=%h", obs(), e);
    end
    n_tot++;
    if ({TOUT_IRQ, TOUT_SLV} !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_tout got=%b want=0", {TOUT_IRQ, TOUT_SLV});
    end
    step();
    HRESET = 1'b0;
  endtask

  task automatic test_mapped();
    HADDR  = 32'h1000_0040;
    HTRANS = 2'b10;
    q.push_back(exp_t'{1'b1, 2'b00, 32'h0});
    @(negedge HCLK);
    n_tot++;
    if (HSEL_S !== 8'h08) begin
      n_bad++;
      $display("FAIL mapped_hsel got=%h want=08", HSEL_S);
    end
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL mapped_addr got=%h want=%h", obs(), e);
    end
    step();
    HTRANS = 2'b00;
    set_slv(3, 1'b1, 2'b00, 32'hDEAD_BEEF);
    q.push_back(exp_t'{1'b1, 2'b00, 32'hDEAD_BEEF});
    @(negedge HCLK);
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL mapped_data got=%h want=%h", obs(), e);
    end
    step();
    q.push_back(exp_t'{1'b1, 2'b00, 32'h0});
    @(negedge HCLK);
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL mapped_idle got=%h want=%h", obs(), e);
    end
    step();
  endtask

  task automatic test_unmapped();
    exp_t seq[5];
    seq[0] = exp_t'{1'b0, 2'b01, 32'h0};
    seq[1] = exp_t'{1'b1, 2'b01, 32'h0};
    seq[2] = exp_t'{1'b0, 2'b01, 32'h0};
    seq[3] = exp_t'{1'b1, 2'b01, 32'h0};
    seq[4] = exp_t'{1'b1, 2'b00, 32'h0};
    HADDR  = 32'hE000_0000;
    HTRANS = 2'b10;
    @(negedge HCLK);
    n_tot++;
    if (HSEL_S !== 8'h00) begin
      n_bad++;
      $display("FAIL unmapped_hsel got=%h want=00", HSEL_S);
    end
    step();
    // Second unmapped transfer rides E1/E2 of the first.
    HADDR = 32'hF000_0000;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) HTRANS = 2'b00;
      q.push_back(seq[k]);
      @(negedge HCLK);
      e = q.pop_front();
      n_tot++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL unmapped_c%0d got=%h want=%h", k, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    HADDR  = 32'h2000_0010;
    HTRANS = 2'b10;
    step();
    HADDR = 32'h3000_0020;
    set_slv(1, 1'b0, 2'b00, 32'h1111_0000);
    for (int k = 0; k < 3; k++) begin
      q.push_back(exp_t'{1'b0, 2'b00, 32'h1111_0000});
      @(negedge HCLK);
      e = q.pop_front();
      n_tot++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL b2b_wait%0d got=%h want=%h", k, obs(), e);
      end
      step();
    end
    set_slv(1, 1'b1, 2'b00, 32'h1111_1111);
    q.push_back(exp_t'{1'b1, 2'b00, 32'h1111_1111});
    @(negedge HCLK);
    n_tot++;
    if (HSEL_S !== 8'h04) begin
      n_bad++;
      $display("FAIL b2b_hsel got=%h want=04", HSEL_S);
    end
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL b2b_s1done got=%h want=%h", obs(), e);
    end
    step();
    HTRANS = 2'b00;
    set_slv(1, 1'b1, 2'b00, dflt(1));
    set_slv(2, 1'b1, 2'b00, 32'h2222_2222);
    q.push_back(exp_t'{1'b1, 2'b00, 32'h2222_2222});
    q.push_back(exp_t'{1'b1, 2'b00, 32'h0});
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      e = q.pop_front();
      n_tot++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL b2b_s2_c%0d got=%h want=%h", k, obs(), e);
      end
      step();
    end
  endtask

  task automatic test_overlap();
    logic [31:0] addr[3];
    logic [7:0]  want[3];
    addr[0] = 32'h0000_0100; want[0] = 8'h01;
    addr[1] = 32'h7FFF_FFFF; want[1] = 8'h80;
    addr[2] = 32'h5000_0000; want[2] = 8'h00;
    HTRANS = 2'b00;
    for (int k = 0; k < 3; k++) begin
      HADDR = addr[k];
      #1;
      n_tot++;
      if (HSEL_S !== want[k]) begin
        n_bad++;
        $display("FAIL overlap_%0d got=%h want=%h", k, HSEL_S, want[k]);
      end
    end
    step();
  endtask

  task automatic test_slave_err();
    HADDR  = 32'h4000_0000;
    HTRANS = 2'b10;
    step();
    HTRANS = 2'b00;
    set_slv(4, 1'b0, 2'b01, 32'h4444_0000);
    q.push_back(exp_t'{1'b0, 2'b01, 32'h4444_0000});
    @(negedge HCLK);
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL slverr_e1 got=%h want=%h", obs(), e);
    end
    step();
    set_slv(4, 1'b1, 2'b01, 32'h4444_0001);
    q.push_back(exp_t'{1'b1, 2'b01, 32'h4444_0001});
    @(negedge HCLK);
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL slverr_e2 got=%h want=%h", obs(), e);
    end
    step();
    set_slv(4, 1'b1, 2'b00, dflt(4));
  endtask

  task automatic test_timeout();
    HADDR  = 32'h6000_0000;
    HTRANS = 2'b10;
    step();
    HTRANS = 2'b00;
    set_slv(6, 1'b0, 2'b00, dflt(6));
`ifdef AHB_MATRIX_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      q.push_back(exp_t'{1'b0, 2'b00, dflt(6)});
      @(negedge HCLK);
      e = q.pop_front();
      n_tot++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL tout_wait%0d got=%h want=%h", k, obs(), e);
      end
      step();
    end
    q.push_back(exp_t'{1'b0, 2'b01, 32'h0});
    q.push_back(exp_t'{1'b1, 2'b01, 32'h0});
    q.push_back(exp_t'{1'b1, 2'b00, 32'h0});
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      e = q.pop_front();
      n_tot++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL tout_seq%0d got=%h want=%h", k, obs(), e);
      end
      n_tot++;
      if ({TOUT_IRQ, TOUT_SLV} !== 5'b1_0110) begin
        n_bad++;
        $display("FAIL tout_flag%0d got=%b want=10110", k, {TOUT_IRQ, TOUT_SLV});
      end
      step();
    end
    TOUT_CLR = 1'b1;
    step();
    TOUT_CLR = 1'b0;
    @(negedge HCLK);
    n_tot++;
    if (TOUT_IRQ !== 1'b0) begin
      n_bad++;
      $display("FAIL tout_clr got=%b want=0", TOUT_IRQ);
    end
    set_slv(6, 1'b1, 2'b00, dflt(6));
    step();
`else
    for (int k = 0; k < 20; k++) begin
      TOUT_CLR = (k == 5);
      q.push_back(exp_t'{1'b0, 2'b00, dflt(6)});
      @(negedge HCLK);
      e = q.pop_front();
      n_tot++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL nodog_wait%0d got=%h want=%h", k, obs(), e);
      end
      step();
    end
    TOUT_CLR = 1'b0;
    n_tot++;
    if ({TOUT_IRQ, TOUT_SLV} !== 5'd0) begin
      n_bad++;
      $display("FAIL nodog_flag got=%b want=0", {TOUT_IRQ, TOUT_SLV});
    end
    set_slv(6, 1'b1, 2'b00, dflt(6));
    q.push_back(exp_t'{1'b1, 2'b00, dflt(6)});
    q.push_back(exp_t'{1'b1, 2'b00, 32'h0});
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      e = q.pop_front();
      n_tot++;
      if (obs() !== e) begin
        n_bad++;
        $display("FAIL nodog_end%0d got=%h want=%h", k, obs(), e);
      end
      step();
    end
`endif
  endtask

  task automatic test_async_reset();
    HADDR  = 32'hE000_0000;
    HTRANS = 2'b10;
    step();
    HTRANS = 2'b00;
    q.push_back(exp_t'{1'b0, 2'b01, 32'h0});
    @(negedge HCLK);
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL arst_e1 got=%h want=%h", obs(), e);
    end
    #2;
    HRESET = 1'b1;
    q.push_back(exp_t'{1'b1, 2'b00, 32'h0});
    #1;
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL arst_mid got=%h want=%h", obs(), e);
    end
    step();
    HRESET = 1'b0;
    HADDR  = 32'h1000_0000;
    HTRANS = 2'b10;
    set_slv(3, 1'b1, 2'b00, 32'hCAFE_F00D);
    step();
    HTRANS = 2'b00;
    q.push_back(exp_t'{1'b1, 2'b00, 32'hCAFE_F00D});
    @(negedge HCLK);
    e = q.pop_front();
    n_tot++;
    if (obs() !== e) begin
      n_bad++;
      $display("FAIL arst_after got=%h want=%h", obs(), e);
    end
    step();
  endtask

  initial begin
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    HRDATA_S    = '0;
    test_reset();
    test_mapped();
    test_unmapped();
    test_back_to_back();
    test_overlap();
    test_slave_err();
    test_timeout();
    test_async_reset();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
